// File: rtl/caxi4interconnect_dwc_upconv_rchan_ctrl_pkg.sv
// Shared types for the upsizer read-data stage: FSM states, burst-type
// encodings and a byte-width helper.
package caxi4interconnect_dwc_upconv_rchan_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_e;

    function automatic int log2_bytes(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/caxi4interconnect_dwc_upconv_rchan_ctrl_outreg.sv
// One-entry narrow R output register; holds a beat stable until mst_rready.
module caxi4interconnect_dwc_upconv_rchan_ctrl_outreg #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [ID_WIDTH-1:0]   load_id,
    input  logic [1:0]            load_resp,
    input  logic                  load_last,
    output logic                  can_accept,
    output logic [DATA_WIDTH-1:0] mst_rdata,
    output logic [ID_WIDTH-1:0]   mst_rid,
    output logic [1:0]            mst_rresp,
    output logic                  mst_rlast,
    output logic                  mst_rvalid,
    input  logic                  mst_rready
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [1:0]            resp_q, resp_d;
    logic                  last_q, last_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        id_d    = id_q;
        resp_d  = resp_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            id_d    = load_id;
            resp_d  = load_resp;
            last_d  = load_last;
        end else if (mst_rready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
            resp_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            id_q    <= id_d;
            resp_q  <= resp_d;
            last_q  <= last_d;
        end
    end

    assign can_accept = !valid_q || mst_rready;
    assign mst_rvalid = valid_q;
    assign mst_rdata  = data_q;
    assign mst_rid    = id_q;
    assign mst_rresp  = resp_q;
    assign mst_rlast  = last_q;

endmodule

// File: rtl/caxi4interconnect_dwc_upconv_rchan_ctrl.sv
// Upsizer read-data stage: slices wide slave R beats into narrow master beats
// and pops a slave beat only once the master burst leaves its lanes.
module caxi4interconnect_dwc_upconv_rchan_ctrl
    import caxi4interconnect_dwc_upconv_rchan_ctrl_pkg::*;
#(
    parameter int SLV_DATA_WIDTH = 128,
    parameter int MST_DATA_WIDTH = 32,
    parameter int ID_WIDTH       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_empty_in,
    output logic                      rd_en_cmd_out,
    input  logic [9:0]                addr_in,
    input  logic [ID_WIDTH-1:0]       arid_in,
    input  logic [7:0]                len_in,
    input  logic [2:0]                size_in,
    input  logic                      fixed_in,
    input  logic                      wrap_in,
    input  logic [9:0]                mask_in,
    input  logic [5:0]                top_in,
    input  logic [SLV_DATA_WIDTH-1:0] slv_rdata,
    input  logic [1:0]                slv_rresp,
    input  logic                      slv_rlast,
    input  logic                      slv_rvalid,
    output logic                      slv_rready,
    output logic [MST_DATA_WIDTH-1:0] mst_rdata,
    output logic [ID_WIDTH-1:0]       mst_rid,
    output logic [1:0]                mst_rresp,
    output logic                      mst_rlast,
    output logic                      mst_rvalid,
    input  logic                      mst_rready,
    output logic                      rlast_err
);

    localparam int SLV_BYTES = SLV_DATA_WIDTH / 8;
    localparam int MST_LOG2  = log2_bytes(MST_DATA_WIDTH);

    state_e              state_q, state_d;
    burst_e              burst_q, burst_d;
    logic [9:0]          addr_q, addr_d;
    logic [9:0]          mask_q, mask_d;
    logic [ID_WIDTH-1:0] arid_q, arid_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          beat_cnt_q, beat_cnt_d;
    logic [2:0]          size_q, size_d;
    logic [5:0]          top_q, top_d;
    logic                rlast_err_q, rlast_err_d;

    logic                      can_accept, produce, last, pop, wrap_hold;
    logic [9:0]                len_ext;
    logic [31:0]               byte_off, slice_idx;
    logic [MST_DATA_WIDTH-1:0] slice_data;

    always_comb begin
        len_ext    = {2'b00, len_q};
        last       = (beat_cnt_q == len_q);
        byte_off   = (32'(addr_q) << size_q) & 32'(SLV_BYTES - 1);
        slice_idx  = byte_off >> MST_LOG2;
        slice_data = MST_DATA_WIDTH'(slv_rdata >> (slice_idx * MST_DATA_WIDTH));
        // A wrap that folds back inside the same slave beat must not pop at its top lane.
        wrap_hold  = (burst_q == BURST_WRAP) && ((addr_q & len_ext) == len_ext)
                     && (len_ext <= mask_q);
        pop        = (burst_q == BURST_FIXED) || last
                     || (((addr_q & mask_q) == {4'b0000, top_q}) && !wrap_hold);
    end

    always_comb begin
        state_d       = state_q;
        burst_d       = burst_q;
        addr_d        = addr_q;
        mask_d        = mask_q;
        arid_d        = arid_q;
        len_d         = len_q;
        beat_cnt_d    = beat_cnt_q;
        size_d        = size_q;
        top_d         = top_q;
        rd_en_cmd_out = 1'b0;
        produce       = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (!cmd_empty_in) begin
                        rd_en_cmd_out = 1'b1;
                        addr_d        = addr_in;
                        arid_d        = arid_in;
                        len_d         = len_in;
                        size_d        = size_in;
                        mask_d        = mask_in;
                        top_d         = top_in;
                        burst_d       = fixed_in ? BURST_FIXED : (wrap_in ? BURST_WRAP : BURST_INCR);
                        beat_cnt_d    = 8'd0;
                        state_d       = ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (slv_rvalid && can_accept) begin
                        produce    = 1'b1;
                        beat_cnt_d = beat_cnt_q + 8'd1;
                        case (burst_q)
                            BURST_FIXED: addr_d = addr_q;
                            BURST_WRAP:  addr_d = (addr_q & ~len_ext) | ((addr_q + 10'd1) & len_ext);
                            default:     addr_d = addr_q + 10'd1;
                        endcase
                        if (last) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            endcase
        end
        slv_rready  = produce && pop;
        rlast_err_d = slv_rready && (slv_rlast != last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            burst_q     <= BURST_INCR;
            addr_q      <= '0;
            mask_q      <= '0;
            arid_q      <= '0;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            size_q      <= '0;
            top_q       <= '0;
            rlast_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            arid_q      <= arid_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            size_q      <= size_d;
            top_q       <= top_d;
            rlast_err_q <= rlast_err_d;
        end
    end

    assign rlast_err = rlast_err_q;

    caxi4interconnect_dwc_upconv_rchan_ctrl_outreg #(
        .DATA_WIDTH (MST_DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH)
    ) u_outreg (
        .clk        (clk),
        .rst        (rst),
        .load       (produce),
        .load_data  (slice_data),
        .load_id    (arid_q),
        .load_resp  (slv_rresp),
        .load_last  (last),
        .can_accept (can_accept),
        .mst_rdata  (mst_rdata),
        .mst_rid    (mst_rid),
        .mst_rresp  (mst_rresp),
        .mst_rlast  (mst_rlast),
        .mst_rvalid (mst_rvalid),
        .mst_rready (mst_rready)
    );

endmodule

// File: doc/caxi4interconnect_dwc_upconv_rchan_ctrl.md
# caxi4interconnect_DWC_UpConv_RChan_Ctrl

Read-data stage of the upsizing data-width converter, directly downstream of the read pre-calculation register slice. It takes one precomputed read command per master burst and the wide slave R channel. It slices each wide slave beat into narrow master beats, generates RID/RLAST, and pops a slave beat only when the master burst leaves that beat's lanes.

## Interface
- SLV_DATA_WIDTH, 128: slave-side (wide) read data width, power of 2, at least MST_DATA_WIDTH.
- MST_DATA_WIDTH, 32: master-side (narrow) read data width, power of 2.
- ID_WIDTH, 4: RID width.
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- cmd_empty_in  in  1  low = command valid at the pre-calc hold register.
- rd_en_cmd_out  out  1  one-cycle pop of the pre-calc hold register.
- addr_in  in  10  start address in units of 2^size bytes.
- arid_in  in  ID_WIDTH  burst ID.
- len_in  in  8  AXI len.
- size_in  in  3  AXI size.
- fixed_in, wrap_in  in  1 each  burst type.
- mask_in  in  10  lanes-per-slave-beat − 1, in size units.
- top_in  in  6  last lane index within a slave beat.
- slv_rdata  in  SLV_DATA_WIDTH  wide read data.
- slv_rresp  in  2  read response.
- slv_rlast  in  1  wide RLAST.
- slv_rvalid  in  1  wide R valid.
- slv_rready  out  1  wide R ready.
- mst_rdata  out  MST_DATA_WIDTH  narrow read data.
- mst_rid  out  ID_WIDTH  narrow RID.
- mst_rresp  out  2  narrow RRESP.
- mst_rlast  out  1  narrow RLAST.
- mst_rvalid  out  1  narrow R valid.
- mst_rready  in  1  narrow R ready.
- rlast_err  out  1  one-cycle pulse on slave/master RLAST mismatch.

## Operation
- FSM with two states, IDLE and XFER.
  - IDLE: when cmd_empty_in=0, assert rd_en_cmd_out for one cycle and latch all command fields. Clear beat_cnt, then go to XFER.
  - XFER: on the beat where beat_cnt==len, go to IDLE.
  - There is one IDLE bubble between bursts.
- Output register, one entry. It can accept a beat when mst_rvalid=0 or mst_rready=1.
- A beat is produced when state=XFER, slv_rvalid=1 and the output register can accept. The output register loads:
  - slice of slv_rdata, with index = ((addr<<size) & (SLV_BYTES−1)) >> log2(MST_BYTES);
  - RID from the latched arid;
  - RRESP from slv_rresp;
  - RLAST = (beat_cnt==len).
- Address update on each produced beat:
  - FIXED: address unchanged.
  - WRAP: addr = (addr & ~len) | ((addr+1) & len).
  - Otherwise: addr+1.
  - beat_cnt increments by 1.
- Pop condition: pop = fixed | last | (rd_src==top && !(wrap && (addr&len)==len && len<=mask)), where rd_src = addr & mask.
  - slv_rready = produce & pop, combinational.
  - The slave beat is consumed in the same cycle as the master beat that pops it.
- Slave beats arrive in master-burst order, including wrap order; this block does not reorder.
- RLAST checking, on a pop: rlast_err pulses if slv_rlast != last. Data still passes; the FSM keeps counting master beats.
- Width rules:
  - Address arithmetic is 10-bit, modulo 2^10.
  - beat_cnt is 8-bit.
  - Slice index width is log2(SLV/MST); 0 bits when the widths are equal, in which case every beat pops.

## Timing
- Reset values: state IDLE; mst_rvalid=0, mst_rlast=0, mst_rdata=0, mst_rid=0, mst_rresp=0; rd_en_cmd_out=0, rlast_err=0; slv_rready=0.
- Reset asserted mid-burst: the burst is abandoned and the output beat is dropped. Upstream reset is shared.
- Command latency:
  - rd_en_cmd_out high in cycle N; XFER from N+1.
  - With slv_rvalid=1 at N+1, mst_rvalid rises at N+2.
- Throughput: one master beat per cycle while mst_rready=1 and slv_rvalid=1.
- Master handshake:
  - mst_rvalid holds with stable data until mst_rready.
  - Never drops without a handshake.
- slv_rready may only be 1 in XFER; it never depends on slv_rvalid in a combinational loop (standard AXI).
- Simultaneous last handshake and a new command: the command is taken on the next cycle in IDLE.

## Structure
- Shared package holds the burst-type encodings (FIXED=0, INCR=1, WRAP=2) and the log2 byte-width helper constants.
- One natural sub-module: caxi4interconnect_DWC_UpConv_RChan_OutReg, the one-entry narrow R output register with valid/ready.

## Test plan
1. INCR, len=3, size=2, addr=0 (SLV=128, MST=32): slices 0,1,2,3; slv_rready once, on beat 4; mst_rlast on beat 4.
2. INCR, len=7, size=2, addr=2: slices 2,3,0,1,2,3,0,1; pops after beats 2, 6 and 8 (3 slave beats); no rlast_err.
3. FIXED, len=3, size=2, addr=1: slice 1 on every beat; 4 slave beats popped.
4. WRAP, len=3, size=2, addr=6: addresses 6,7,4,5 give slices 2,3,0,1; single pop at the last beat. Then WRAP, len=7, addr=6: pops at beat 2 (addr 7), again at beat 6, and at the last beat.
5. mst_rready held low 3 cycles mid-burst (case 2): mst_rdata/mst_rid/mst_rlast stable, slv_rready=0, no beat lost or duplicated.
6. slv_rlast=1 on the first pop of case 2: rlast_err pulses once. Reset asserted on beat 3: all outputs return to reset values next cycle, and a new command starts cleanly.
